fft_bfly_unit: RTL

- Multi-cycle radix-2 DIT butterfly coprocessor in the EX stage, beside the ALU.
- Consumes forwarded operand A (forward_data_a) and B (forward_data_b) plus a twiddle index from the immediate.
- Result goes to the EX/MEM alu_result path through the existing FFT/ALU result mux.
- Stalls PC, IF/ID and ID/EX while a butterfly is in flight.

---
 rtl/fft_bfly_unit_pkg.sv | 65 ++++++
 rtl/fft_bfly_unit_if.sv | 25 ++
 rtl/fft_twiddle_rom.sv | 32 +++
 rtl/fft_bfly_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fft_bfly_unit_pkg.sv
// Shared definitions for the radix-2 DIT butterfly coprocessor:
// instruction encodings, FSM states, Q1.15 constants and twiddle generation.
package fft_bfly_unit_pkg;

  localparam logic [6:0] FFT_OPCODE  = 7'b0001011;  // custom-0
  localparam logic [2:0] FFT_F3_BFLY = 3'b000;
  localparam logic [2:0] FFT_F3_RDHI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } bfly_state_e;

  localparam int Q15_RND_BIAS = 1 << 14;
  localparam int Q15_SAT_MAX  = 32767;
  localparam int Q15_SAT_MIN  = -32768;

  localparam longint TW_PI_Q28  = 64'sd843314857;
  localparam longint TW_ONE_Q28 = 64'sd268435456;

  // One twiddle component at elaboration time: real = cos, imag = -sin of
  // pi*k/2^tw_bits. Integer Taylor series in Q28 keeps it free of real math;
  // angles past pi/2 are folded back so the series stays well converged.
  function automatic int tw_comp(input int k, input int tw_bits, input int dw,
                                 input bit is_imag);
    longint x, x2, term, acc, mag, rnd, half, kk, lim;
    bit     neg;
    int     sh;
    half = longint'(1) <<< tw_bits;
    kk   = longint'(k);
    neg  = 1'b0;
    if (2 * kk > half) begin
      kk  = half - kk;
      neg = 1'b1;
    end
    x  = (TW_PI_Q28 * kk) >>> tw_bits;
    x2 = (x * x) >>> 28;
    if (is_imag) begin
      term = x;
      acc  = x;
    end else begin
      term = TW_ONE_Q28;
      acc  = TW_ONE_Q28;
    end
    for (int n = 1; n <= 8; n++) begin
      if (is_imag)
        term = -(((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1)));
      else
        term = -(((term * x2) >>> 28) / longint'((2 * n - 1) * (2 * n)));
      acc = acc + term;
    end
    mag = (acc < 64'sd0) ? 64'sd0 : acc;
    sh  = 28 - (dw - 1);
    rnd = (mag + (longint'(1) <<< (sh - 1))) >>> sh;
    lim = (longint'(1) <<< (dw - 1)) - 1;
    // +/-1.0 clamps to the symmetric code (0x7FFF / 0x8001)
    if (rnd > lim) rnd = lim;
    if (is_imag || neg) rnd = -rnd;
    return int'(rnd);
  endfunction

endpackage

// File: rtl/fft_bfly_unit_if.sv
// Handshake/bus bundle between the EX stage and the butterfly unit.
interface fft_bfly_unit_if #(
  parameter int DW      = 16,
  parameter int TW_BITS = 4
);
  logic                start_i;
  logic                op_i;
  logic [2*DW-1:0]     a_i;
  logic [2*DW-1:0]     b_i;
  logic [TW_BITS-1:0]  tw_idx_i;
  logic                flush_i;
  logic                stall_o;
  logic                done_o;
  logic [2*DW-1:0]     result_o;

  modport master (
    output start_i, op_i, a_i, b_i, tw_idx_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, tw_idx_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM: {Wr, Wi} in Q1.15, one registered read per accepted butterfly.
module fft_twiddle_rom
  import fft_bfly_unit_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TW_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [TW_BITS-1:0] i_idx,
  output logic [2*DW-1:0]    o_w
);
  localparam int ENTRIES = 2 ** TW_BITS;

  logic [2*DW-1:0] w_rom [ENTRIES];
  logic [2*DW-1:0] r_w;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_rom
    localparam int WR = tw_comp(g, TW_BITS, DW, 1'b0);
    localparam int WI = tw_comp(g, TW_BITS, DW, 1'b1);
    assign w_rom[g] = {WR[DW-1:0], WI[DW-1:0]};
  end

  // Latch the twiddle only on acceptance so it stays stable for both multiply cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_w <= '0;
    else if (i_en) r_w <= w_rom[i_idx];
  end

  assign o_w = r_w;
endmodule

// File: rtl/fft_bfly_unit.sv
// Multi-cycle radix-2 DIT butterfly next to the ALU.
//   state | meaning
//   IDLE  | waiting; BFLY captures operands, RDHI answers same cycle
//   MUL1  | p0 = Br*Wr, p1 = Bi*Wi
//   MUL2  | p2 = Br*Wi, p3 = Bi*Wr
//   ADD   | round T, form A' and B'
//   DONE  | A' on result, B' committed at exit edge, pipeline released
module fft_bfly_unit
  import fft_bfly_unit_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TW_BITS = 4,
  parameter int SCALE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  fft_bfly_unit_if.slave   bus
);
  localparam logic signed [2*DW:0] L_SAT_MAX  = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [2*DW:0] L_SAT_MIN  = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});
  localparam logic signed [2*DW:0] L_RND_BIAS = $signed({{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}});

  bfly_state_e r_state, w_state_nxt;

  logic [2*DW-1:0]        r_a, r_b, r_result, r_bnew, r_bhi, w_tw;
  logic signed [2*DW-1:0] r_p0, r_p1, r_p2, r_p3, w_m0, w_m1;
  logic signed [DW-1:0]   w_ar, w_ai, w_br, w_bi, w_wr, w_wi, w_m0_y, w_m1_y, w_tr, w_ti;
  logic signed [2*DW:0]   w_tr_acc, w_ti_acc;
  logic signed [DW:0]     w_ar_sum, w_ai_sum, w_br_dif, w_bi_dif;
  logic [2*DW-1:0]        w_a_new, w_b_new;
  logic                   w_accept, w_rdhi;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [2*DW:0] x);
    if (x > L_SAT_MAX)      return L_SAT_MAX[DW-1:0];
    else if (x < L_SAT_MIN) return L_SAT_MIN[DW-1:0];
    else                    return x[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] scale_sat(input logic signed [DW:0] x);
    logic signed [DW:0] s;
    s = x >>> SCALE;
    return sat_dw({{DW{s[DW]}}, s});
  endfunction

  fft_twiddle_rom #(.DW(DW), .TW_BITS(TW_BITS)) u_rom (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_accept),
    .i_idx (bus.tw_idx_i),
    .o_w   (w_tw)
  );

  assign w_ar = r_a[2*DW-1:DW];
  assign w_ai = r_a[DW-1:0];
  assign w_br = r_b[2*DW-1:DW];
  assign w_bi = r_b[DW-1:0];
  assign w_wr = w_tw[2*DW-1:DW];
  assign w_wi = w_tw[DW-1:0];

  // Two shared multipliers; the twiddle operands swap between MUL1 and MUL2
  assign w_m0_y = (r_state == S_MUL1) ? w_wr : w_wi;
  assign w_m1_y = (r_state == S_MUL1) ? w_wi : w_wr;
  assign w_m0   = w_br * w_m0_y;
  assign w_m1   = w_bi * w_m1_y;

  assign w_tr_acc = ({r_p0[2*DW-1], r_p0} - {r_p1[2*DW-1], r_p1}) + L_RND_BIAS;
  assign w_ti_acc = ({r_p2[2*DW-1], r_p2} + {r_p3[2*DW-1], r_p3}) + L_RND_BIAS;
  assign w_tr     = sat_dw(w_tr_acc >>> (DW-1));
  assign w_ti     = sat_dw(w_ti_acc >>> (DW-1));

  assign w_ar_sum = {w_ar[DW-1], w_ar} + {w_tr[DW-1], w_tr};
  assign w_ai_sum = {w_ai[DW-1], w_ai} + {w_ti[DW-1], w_ti};
  assign w_br_dif = {w_ar[DW-1], w_ar} - {w_tr[DW-1], w_tr};
  assign w_bi_dif = {w_ai[DW-1], w_ai} - {w_ti[DW-1], w_ti};
  assign w_a_new  = {scale_sat(w_ar_sum), scale_sat(w_ai_sum)};
  assign w_b_new  = {scale_sat(w_br_dif), scale_sat(w_bi_dif)};

  // Next state and handshake outputs; flush overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_rdhi       = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start_i && !bus.op_i) w_state_nxt = S_MUL1;
      S_MUL1: w_state_nxt = S_MUL2;
      S_MUL2: w_state_nxt = S_ADD;
      S_ADD:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) w_state_nxt = S_IDLE;
    if (r_state == S_IDLE && bus.start_i && !bus.flush_i) begin
      w_accept = !bus.op_i;
      w_rdhi   = bus.op_i;
    end
    bus.stall_o  = bus.start_i && !bus.op_i && (r_state != S_DONE);
    bus.done_o   = ((r_state == S_DONE) || w_rdhi) && !bus.flush_i;
    bus.result_o = w_rdhi ? r_bhi : r_result;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Operand capture, product pipeline and result/B' registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_p3     <= '0;
      r_result <= '0;
      r_bnew   <= '0;
      r_bhi    <= '0;
    end else begin
      if (w_accept) begin
        r_a <= bus.a_i;
        r_b <= bus.b_i;
      end
      if (r_state == S_MUL1) begin
        r_p0 <= w_m0;
        r_p1 <= w_m1;
      end
      if (r_state == S_MUL2) begin
        r_p2 <= w_m0;
        r_p3 <= w_m1;
      end
      if (r_state == S_ADD && !bus.flush_i) begin
        r_result <= w_a_new;
        r_bnew   <= w_b_new;
      end
      // B' becomes visible to RDHI only once the butterfly retires
      if (r_state == S_DONE && !bus.flush_i) r_bhi <= r_bnew;
      if (w_rdhi) r_result <= r_bhi;
    end
  end

endmodule
